// File: rtl/axi_stream_skid_buffer_if.sv
// AXI4-Stream bundle used on both sides of the skid buffer.
// master drives valid and payload; slave drives ready.
interface axi_stream_skid_buffer_if #(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [8*byte_width-1:0] tdata;
  logic [byte_width-1:0]   tstrb;
  logic [byte_width-1:0]   tkeep;
  logic                    tlast;
  logic [id_width-1:0]     tid;
  logic [dest_width-1:0]   tdest;
  logic [user_width-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry AXI4-Stream register slice: every output, including s.tready,
// comes straight from a flop, so neither the ready nor the payload path is combinational.
module axi_stream_skid_buffer #(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  axi_stream_skid_buffer_if.slave         s,
  axi_stream_skid_buffer_if.master        m,
  output logic [1:0]                      occupancy
);
  localparam int payload_width = 8*byte_width + 2*byte_width + 1
                               + id_width + dest_width + user_width;

  logic [payload_width-1:0] s_payload;
  logic [payload_width-1:0] out_payload_reg;
  logic [payload_width-1:0] skid_payload_reg;
  logic                     out_valid_reg;
  logic                     skid_valid_reg;
  logic                     s_ready_reg;
  logic                     skid_valid_next;
  logic                     accept;
  logic                     out_free;

  assign s_payload = {s.tdata, s.tstrb, s.tkeep, s.tlast, s.tid, s.tdest, s.tuser};

  assign accept   = s.tvalid && s_ready_reg;
  assign out_free = !out_valid_reg || m.tready;

  // SKID can only fill while OUT is stalled; whenever OUT frees it takes the SKID beat first.
  assign skid_valid_next = !out_free && (skid_valid_reg || accept);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_reg    <= 1'b0;
      skid_valid_reg   <= 1'b0;
      s_ready_reg      <= 1'b0;
      out_payload_reg  <= '0;
      skid_payload_reg <= '0;
    end else begin
      if (out_free) begin
        if (skid_valid_reg) begin
          out_payload_reg <= skid_payload_reg;
        end else if (accept) begin
          out_payload_reg <= s_payload;
        end
        out_valid_reg <= skid_valid_reg || accept;
      end else if (accept) begin
        skid_payload_reg <= s_payload;
      end
      skid_valid_reg <= skid_valid_next;
      s_ready_reg    <= !skid_valid_next;
    end
  end

  assign s.tready = s_ready_reg;
  assign m.tvalid = out_valid_reg;
  assign {m.tdata, m.tstrb, m.tkeep, m.tlast, m.tid, m.tdest, m.tuser} = out_payload_reg;

  assign occupancy = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg};
endmodule

// File: tb/tb_axi_stream_skid_buffer.sv
// Directed and random bench for the skid buffer, checked against an in-order
// beat queue that models the buffer as a two-deep FIFO with registered ready.
module tb_axi_stream_skid_buffer;
  localparam int BW = 4;
  localparam int IW = 2;
  localparam int DW = 3;
  localparam int UW = 2;

  typedef struct packed {
    logic [8*BW-1:0] data;
    logic [BW-1:0]   strb;
    logic [BW-1:0]   keep;
    logic            last;
    logic [IW-1:0]   id;
    logic [DW-1:0]   dest;
    logic [UW-1:0]   user;
  } beat_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] occupancy;

  axi_stream_skid_buffer_if #(.byte_width(BW), .id_width(IW), .dest_width(DW), .user_width(UW)) s_if ();
  axi_stream_skid_buffer_if #(.byte_width(BW), .id_width(IW), .dest_width(DW), .user_width(UW)) m_if ();

  axi_stream_skid_buffer #(
    .byte_width(BW), .id_width(IW), .dest_width(DW), .user_width(UW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s         (s_if),
    .m         (m_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    beats_out = 0;
  beat_t q[$];
  bit    armed = 1'b0;
  bit    last_acc = 1'b0;
  beat_t cur_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = 32'($urandom);
    b.keep = BW'($urandom);
    b.strb = BW'($urandom) & b.keep;
    b.last = 1'($urandom);
    b.id   = IW'($urandom);
    b.dest = DW'($urandom);
    b.user = UW'($urandom);
    return b;
  endfunction

  task automatic drive(input logic v, input beat_t b);
    cur_beat     = b;
    s_if.tvalid  = v;
    s_if.tdata   = b.data;
    s_if.tstrb   = b.strb;
    s_if.tkeep   = b.keep;
    s_if.tlast   = b.last;
    s_if.tid     = b.id;
    s_if.tdest   = b.dest;
    s_if.tuser   = b.user;
  endtask

  task automatic check_outputs();
    check("m_tvalid", 64'(m_if.tvalid), 64'(q.size() > 0));
    check("s_tready", 64'(s_if.tready), 64'(armed && q.size() < 2));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    if (q.size() > 0) begin
      check("m_tdata", 64'(m_if.tdata), 64'(q[0].data));
      check("m_side", 64'({m_if.tstrb, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser}),
            64'({q[0].strb, q[0].keep, q[0].last, q[0].id, q[0].dest, q[0].user}));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'(0));
    check({tag, "_s_tready"}, 64'(s_if.tready), 64'(0));
    check({tag, "_occupancy"}, 64'(occupancy), 64'(0));
    check({tag, "_m_tdata"}, 64'(m_if.tdata), 64'(0));
  endtask

  // One clock: predict handshakes from the model's state, advance the model, then compare.
  task automatic cycle();
    bit acc;
    bit drn;
    acc = (s_if.tvalid === 1'b1) && armed && (q.size() < 2);
    drn = (q.size() > 0) && (m_if.tready === 1'b1);
    @(posedge clk);
    if (resetn) begin
      if (drn) begin
        $display("beat %0d out data=%08h strb=%h keep=%h last=%0b", beats_out, q[0].data,
                 q[0].strb, q[0].keep, q[0].last);
        beats_out++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(cur_beat);
      armed = 1'b1;
    end
    last_acc = acc;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    beat_t b;
    m_if.tready = 1'b0;
    drive(1'b0, '0);

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    resetn = 1'b1;
    cycle();

    // Streaming 8 beats with m_tready tied high
    m_if.tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      b = rand_beat();
      b.data = 32'(i);
      b.keep = 4'hF;
      b.strb = 4'hF;
      b.last = (i == 8);
      drive(1'b1, b);
      cycle();
    end
    drive(1'b0, '0);
    repeat (2) cycle();

    // Backpressure: A then B stall, then release
    m_if.tready = 1'b0;
    b = rand_beat(); b.data = 32'hAAAA5555; drive(1'b1, b); cycle();
    b = rand_beat(); b.data = 32'h12345678; drive(1'b1, b); cycle();
    check("bp_full_data", 64'(m_if.tdata), 64'h0000_0000_AAAA_5555);
    check("bp_full_ready", 64'(s_if.tready), 64'(0));
    drive(1'b0, '0);
    m_if.tready = 1'b1;
    cycle();
    check("bp_second_data", 64'(m_if.tdata), 64'h0000_0000_1234_5678);
    cycle();

    // Simultaneous accept and drain at occupancy 1
    m_if.tready = 1'b0;
    drive(1'b1, rand_beat()); cycle();
    b = rand_beat(); b.keep = 4'hF; b.strb = 4'h5;
    m_if.tready = 1'b1;
    drive(1'b1, b); cycle();
    check("sim_strb", 64'(m_if.tstrb), 64'h5);
    check("sim_occ", 64'(occupancy), 64'h1);
    drive(1'b0, '0); cycle();

    // Random traffic; an unaccepted beat is held until it is taken
    last_acc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!(s_if.tvalid === 1'b1 && !last_acc)) begin
        drive(($urandom_range(0, 3) != 0), rand_beat());
      end
      m_if.tready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drive(1'b0, '0);
    m_if.tready = 1'b1;
    repeat (3) cycle();
    check("drained", 64'(occupancy), 64'(0));

    // Reset while full
    m_if.tready = 1'b0;
    for (int i = 0; i < 4 && q.size() < 2; i++) begin
      drive(1'b1, rand_beat());
      cycle();
    end
    check("pre_reset_occ", 64'(occupancy), 64'h2);
    #2 resetn = 1'b0;
    #1;
    q.delete();
    armed = 1'b0;
    check_reset_state("async_reset");
    drive(1'b0, '0);
    m_if.tready = 1'b1;
    @(negedge clk);
    check_reset_state("held_reset");
    resetn = 1'b1;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_skid_buffer.md
Name: axi_stream_skid_buffer

Overview:
- Full-throughput, two-entry AXI4-Stream register slice (skid buffer).
- Breaks the combinational timing path on TREADY and on the forward payload.
- Sits directly upstream of any AXI-Stream master port, and drives that port from registers only.
- The master-side port must satisfy every AXI4-Stream master rule: TVALID held until handshake, payload stable under stall, TVALID low in reset, TSTRB only where TKEEP is set.

Parameters:
- byte_width, 4, TDATA bytes; TDATA is 8*byte_width bits; TSTRB/TKEEP are byte_width bits; must be >= 1.
- id_width, 1, TID width; must be >= 1 (tie port to 0 if unused).
- dest_width, 1, TDEST width; must be >= 1.
- user_width, 1, TUSER width; must be >= 1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset; assertion takes effect immediately; release is sampled on clk.
- s_tvalid  input  1  slave-side valid.
- s_tready  output  1  slave-side ready; a register output.
- s_tdata  input  8*byte_width  slave payload.
- s_tstrb, s_tkeep  input  byte_width  slave byte qualifiers.
- s_tlast  input  1  slave packet boundary.
- s_tid, s_tdest, s_tuser  input  id_width/dest_width/user_width  slave sideband.
- m_tvalid  output  1  master-side valid; a register output.
- m_tready  input  1  master-side ready.
- m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  output  same widths as the matching s_* inputs  master payload; register outputs.
- occupancy  output  2  number of beats held: 0, 1 or 2.

Behaviour:
- Storage:
  - OUT stage: drives the m_* outputs.
  - SKID stage: skid_valid plus a full payload copy.
- Reset (resetn low, asynchronous):
  - m_tvalid = 0, skid_valid = 0, s_tready = 0, occupancy = 0.
  - All m_* payload outputs and the skid payload = 0.
  - Beats held when reset asserts are discarded, including reset mid-packet or mid-stall.
- Reset release:
  - s_tready rises at the first clk edge sampled with resetn high.
  - m_tvalid stays 0 until a beat is accepted.
- Handshake terms:
  - accept = s_tvalid && s_tready.
  - drain = m_tvalid && m_tready.
- Per rising edge (resetn high):
  - If !m_tvalid or m_tready (OUT free or draining):
    - If skid_valid: OUT <= SKID and skid_valid <= 0.
    - Else if accept: OUT <= s_* payload.
    - Otherwise OUT payload is held.
    - m_tvalid <= skid_valid | accept.
  - Else (OUT stalled):
    - If accept: SKID <= s_* payload and skid_valid <= 1.
    - OUT is unchanged.
  - s_tready <= !skid_valid_next, i.e. ready is low exactly while SKID is full.
- occupancy = m_tvalid + skid_valid, computed from registers.
- Latency: 1 cycle from accept to m_tvalid when empty.
- Throughput: 1 beat/cycle sustained while m_tready is high.
- Ordering: beats leave in acceptance order. SKID always holds the younger beat, and OUT always refills from SKID before taking new input.
- Stall rules:
  - While m_tvalid && !m_tready, all m_* payload bits are stable and m_tvalid stays high.
  - m_tvalid never falls except after drain or reset.
  - m_tvalid must not depend combinationally on m_tready.
- Payload pass-through is bit-exact; the block never alters TSTRB/TKEEP/TLAST.
- Boundary conditions:
  - Full (occupancy 2) with m_tready high:
    - OUT <= SKID, skid_valid <= 0.
    - s_tready rises next cycle.
    - No input is accepted this cycle, since s_tready = 0.
  - Occupancy 1 with simultaneous accept and drain: OUT <= new beat, occupancy stays 1.
  - Occupancy 1 with accept and no drain: occupancy becomes 2 and s_tready falls next cycle.
  - Empty with m_tready low and accept: OUT loads the beat; m_tvalid rises regardless of m_tready.
  - s_tvalid with s_tready low: no state change; upstream must hold its own beat.
  - No beat is ever dropped or duplicated outside reset.

Test Plan:
- Streaming: reset, then tie m_tready=1 and drive 8 beats with tdata=0x00000001..0x00000008 and tlast on beat 8 -> m_tvalid high cycles 1..8 after first accept, same data in order, tlast on the 8th, occupancy stays 1, s_tready constant 1.
- Backpressure: m_tready=0 while s_tvalid=1 with data A=0xAAAA5555 then B=0x12345678 -> m_tdata holds A, occupancy=2, s_tready=0 next cycle. Raise m_tready for 2 cycles -> A then B emitted, s_tready returns 1 one cycle after A drains.
- Random m_tready/s_tvalid for 2000 cycles with a scoreboard -> zero loss, duplication or reorder. m_* is stable whenever m_tvalid && !m_tready. tstrb/tkeep/tuser/tid/tdest match per beat.
- Reset mid-operation: assert resetn low asynchronously while occupancy=2 -> m_tvalid, s_tready and occupancy are 0 before the next clk edge. After release, s_tready=1 one edge later and no stale beat appears.
- Simultaneous accept+drain at occupancy 1 with tkeep=0xF, tstrb=0x5 -> the new beat appears next cycle with tstrb=0x5, and occupancy remains 1.
- Formal: attach the team's AXI-Stream master property monitor to the m_* port with USE_ASYNC_RESET=1. The induction proof passes with s_* unconstrained except for the slave-side handshake-hold assumption.
